// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the memory game core: FSM state encoding,
// LFSR feedback mask and one-hot utilities.
package memory_game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHOW_ON,
      SHOW_OFF,
      INPUT,
      WIN,
      LOSE
   } state_t;

   // Right-shifting Galois form of taps 16,14,13,11.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] onehot(input logic [3:0] idx, input int width);
      logic [15:0] v;
      v = 16'h0001 << idx;
      if (int'(idx) >= width) v = 16'h0000;
      return v;
   endfunction

   function automatic logic is_onehot(input logic [15:0] v);
      return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
   endfunction

endpackage

// File: rtl/memory_game_lfsr.sv
// 16-bit Galois LFSR; steps once per cycle that i_adv is high.
module game_lfsr
   import memory_game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_adv,
   output logic [15:0] o_val
);

   logic [15:0] r_val;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_val <= SEED;
      end else if (i_adv) begin
         r_val <= {1'b0, r_val[15:1]} ^ (r_val[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign o_val = r_val;

endmodule

// File: rtl/memory_game_core.sv
// Memory game controller: grows a pseudo-random sequence, plays it back on the
// LEDs and checks the player's presses against it.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | after reset, waiting for a start edge
// SHOW_ON  | current sequence entry lit on its LED
// SHOW_OFF | dark gap after a playback step
// INPUT    | echoing buttons, checking presses, timeout running
// WIN      | full sequence repeated, all LEDs on
// LOSE     | wrong press or timeout, score frozen
module memory_game_core
   import memory_game_pkg::*;
#(
   parameter int          NUM_CH      = 4,
   parameter int          CLK_PER_SEC = 50_000_000,
   parameter int          GAME_LIMIT  = 8,
   parameter int          ON_CYC      = CLK_PER_SEC / 2,
   parameter int          OFF_CYC     = CLK_PER_SEC / 2,
   parameter int          TIMEOUT_CYC = 3 * CLK_PER_SEC,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          SCORE_W     = $clog2(GAME_LIMIT + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [NUM_CH-1:0]  i_btn,
   output logic [NUM_CH-1:0]  o_led,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_busy,
   output logic               o_win,
   output logic               o_lose
);

   localparam int CH_W    = $clog2(NUM_CH);
   localparam int T_MAX1  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int T_MAX   = (T_MAX1 > TIMEOUT_CYC) ? T_MAX1 : TIMEOUT_CYC;
   localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int SEQ_D   = 2 ** SCORE_W;

   localparam logic [TIMER_W-1:0] T_ON  = TIMER_W'(ON_CYC - 1);
   localparam logic [TIMER_W-1:0] T_OFF = TIMER_W'(OFF_CYC - 1);
   localparam logic [TIMER_W-1:0] T_TO  = TIMER_W'(TIMEOUT_CYC - 1);
   localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
   localparam logic [SCORE_W-1:0] S_ONE = SCORE_W'(1);
   localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(GAME_LIMIT);

   state_t              r_state;
   logic                r_start_q;
   logic [NUM_CH-1:0]   r_btn_q;
   logic [SCORE_W-1:0]  r_level;
   logic [SCORE_W-1:0]  r_idx;
   logic [TIMER_W-1:0]  r_timer;
   logic [NUM_CH-1:0]   r_led;
   logic [SCORE_W-1:0]  r_score;
   logic                r_busy;
   logic                r_win;
   logic                r_lose;

   // Sized to the full index range so every select stays in bounds; only the
   // first GAME_LIMIT entries are ever written.
   logic [CH_W-1:0]     r_seq [SEQ_D];

   logic [15:0]         w_lfsr;
   logic                w_start_p;
   logic [NUM_CH-1:0]   w_press;
   logic [CH_W-1:0]     w_entry;
   logic [SCORE_W-1:0]  w_idx_inc;
   logic [SCORE_W-1:0]  w_wr_idx;
   logic [NUM_CH-1:0]   w_oh_entry;
   logic [NUM_CH-1:0]   w_oh_cur;
   logic [NUM_CH-1:0]   w_oh_nxt;
   logic [NUM_CH-1:0]   w_oh_first;
   logic                w_last;
   logic                w_start_go;
   logic                w_correct;
   logic                w_adv;

   assign w_start_p  = i_start & ~r_start_q;
   assign w_press    = i_btn & ~r_btn_q;
   assign w_entry    = CH_W'(w_lfsr % NUM_CH);
   assign w_idx_inc  = r_idx + S_ONE;
   assign w_last     = (r_idx == (r_level - S_ONE));

   assign w_oh_entry = NUM_CH'(onehot(4'(w_entry), NUM_CH));
   assign w_oh_cur   = NUM_CH'(onehot(4'(r_seq[r_idx]), NUM_CH));
   assign w_oh_nxt   = NUM_CH'(onehot(4'(r_seq[w_idx_inc]), NUM_CH));
   assign w_oh_first = NUM_CH'(onehot(4'(r_seq[0]), NUM_CH));

   assign w_start_go = w_start_p &&
                       ((r_state == IDLE) || (r_state == WIN) || (r_state == LOSE));
   assign w_correct  = (r_state == INPUT) && is_onehot(16'(w_press)) &&
                       (w_press == w_oh_cur);
   // The LFSR only steps when a new entry is appended to the sequence.
   assign w_adv      = w_start_go || (w_correct && w_last && (r_level != LIMIT));
   assign w_wr_idx   = w_start_go ? '0 : r_level;

   game_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_adv (w_adv),
      .o_val (w_lfsr)
   );

   always_ff @(posedge i_clk) begin
      if (w_adv) r_seq[w_wr_idx] <= w_entry;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_start_q <= 1'b0;
         r_btn_q   <= '0;
         r_level   <= '0;
         r_idx     <= '0;
         r_timer   <= '0;
         r_led     <= '0;
         r_score   <= '0;
         r_busy    <= 1'b0;
         r_win     <= 1'b0;
         r_lose    <= 1'b0;
      end else begin
         r_start_q <= i_start;
         r_btn_q   <= i_btn;
         case (r_state)
            IDLE, WIN, LOSE: begin
               if (w_start_p) begin
                  r_state <= SHOW_ON;
                  r_level <= S_ONE;
                  r_idx   <= '0;
                  r_timer <= T_ON;
                  r_led   <= w_oh_entry;
                  r_score <= '0;
                  r_busy  <= 1'b1;
                  r_win   <= 1'b0;
                  r_lose  <= 1'b0;
               end
            end
            SHOW_ON: begin
               if (r_timer == '0) begin
                  r_state <= SHOW_OFF;
                  r_timer <= T_OFF;
                  r_led   <= '0;
               end else begin
                  r_timer <= r_timer - T_ONE;
               end
            end
            SHOW_OFF: begin
               if (r_timer == '0) begin
                  if (w_last) begin
                     r_state <= INPUT;
                     r_idx   <= '0;
                     r_timer <= T_TO;
                     r_led   <= i_btn;
                  end else begin
                     r_state <= SHOW_ON;
                     r_idx   <= w_idx_inc;
                     r_timer <= T_ON;
                     r_led   <= w_oh_nxt;
                  end
               end else begin
                  r_timer <= r_timer - T_ONE;
               end
            end
            INPUT: begin
               r_led <= i_btn;
               // A press outranks an expiring timer in the same cycle.
               if (w_press != '0) begin
                  if (w_correct) begin
                     r_timer <= T_TO;
                     if (w_last) begin
                        r_score <= r_level;
                        if (r_level == LIMIT) begin
                           r_state <= WIN;
                           r_led   <= '1;
                           r_busy  <= 1'b0;
                           r_win   <= 1'b1;
                        end else begin
                           r_state <= SHOW_ON;
                           r_level <= r_level + S_ONE;
                           r_idx   <= '0;
                           r_timer <= T_ON;
                           r_led   <= w_oh_first;
                        end
                     end else begin
                        r_idx <= w_idx_inc;
                     end
                  end else begin
                     r_state <= LOSE;
                     r_led   <= '0;
                     r_busy  <= 1'b0;
                     r_lose  <= 1'b1;
                  end
               end else if (r_timer == '0) begin
                  r_state <= LOSE;
                  r_led   <= '0;
                  r_busy  <= 1'b0;
                  r_lose  <= 1'b1;
               end else begin
                  r_timer <= r_timer - T_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_led   <= '0;
               r_busy  <= 1'b0;
               r_win   <= 1'b0;
               r_lose  <= 1'b0;
            end
         endcase
      end
   end

   assign o_led   = r_led;
   assign o_score = r_score;
   assign o_busy  = r_busy;
   assign o_win   = r_win;
   assign o_lose  = r_lose;

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench for memory_game_core with short timing parameters and a
// reference LFSR/sequence model.
module tb_memory_game_core;

   localparam int NUM_CH = 4;
   localparam int CPS    = 6;
   localparam int GL     = 3;
   localparam int ON     = 3;
   localparam int OFF    = 3;
   localparam int TO     = 18;
   localparam int SW     = 2;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    btn   = 4'b0000;
   logic [3:0]    o_led;
   logic [SW-1:0] o_score;
   logic          o_busy;
   logic          o_win;
   logic          o_lose;

   int          vecs = 0;
   int          errs = 0;
   logic [15:0] m_lfsr;
   int          m_seq [GL];
   int          m_level;
   int          c0;

   always #5 clk = ~clk;

   memory_game_core #(
      .NUM_CH      (NUM_CH),
      .CLK_PER_SEC (CPS),
      .GAME_LIMIT  (GL),
      .ON_CYC      (ON),
      .OFF_CYC     (OFF),
      .TIMEOUT_CYC (TO),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_btn   (btn),
      .o_led   (o_led),
      .o_score (o_score),
      .o_busy  (o_busy),
      .o_win   (o_win),
      .o_lose  (o_lose)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] oh(input int ch);
      logic [3:0] v;
      v = 4'b0001 << ch;
      return v;
   endfunction

   task automatic m_append();
      m_seq[m_level] = int'(m_lfsr % 16'd4);
      m_level++;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   endtask

   task automatic do_start();
      m_level = 0;
      m_append();
      start = 1'b1;
      step();
      start = 1'b0;
      vecs++;
      if (o_busy !== 1'b1 || o_win !== 1'b0 || o_lose !== 1'b0 || o_score !== 2'd0) begin
         errs++;
         $display("FAIL start_flags: busy=%b win=%b lose=%b score=%0d, want 1 0 0 0",
                  o_busy, o_win, o_lose, o_score);
      end
   endtask

   // Checks a full playback of n entries starting at the first lit cycle and
   // ends on the first INPUT cycle.
   task automatic play(input int n, input bit poke);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < ON; j++) begin
            vecs++;
            if (o_led !== oh(m_seq[i]) || o_busy !== 1'b1) begin
               errs++;
               $display("FAIL play_on step %0d cyc %0d: led=%b busy=%b, want led=%b busy=1",
                        i, j, o_led, o_busy, oh(m_seq[i]));
            end
            if (poke && i == 0) start = (j == 1);
            step();
         end
         for (int j = 0; j < OFF; j++) begin
            vecs++;
            if (o_led !== 4'b0000 || o_busy !== 1'b1) begin
               errs++;
               $display("FAIL play_off step %0d cyc %0d: led=%b busy=%b, want led=0000 busy=1",
                        i, j, o_led, o_busy);
            end
            step();
         end
      end
      vecs++;
      if (o_busy !== 1'b1 || o_led !== 4'b0000 || o_win !== 1'b0 || o_lose !== 1'b0) begin
         errs++;
         $display("FAIL input_entry: busy=%b led=%b win=%b lose=%b, want 1 0000 0 0",
                  o_busy, o_led, o_win, o_lose);
      end
   endtask

   // Replays r entries with 1-cycle presses 4 cycles apart; returns right
   // after the edge that samples the last press.
   task automatic press_seq(input int r);
      for (int k = 0; k < r; k++) begin
         btn = oh(m_seq[k]);
         step();
         btn = 4'b0000;
         if (k < r - 1) begin
            vecs++;
            if (o_led !== oh(m_seq[k]) || o_busy !== 1'b1 || o_lose !== 1'b0 ||
                o_score !== SW'(r - 1)) begin
               errs++;
               $display("FAIL press_mid r%0d k%0d: led=%b busy=%b lose=%b score=%0d, want %b 1 0 %0d",
                        r, k, o_led, o_busy, o_lose, o_score, oh(m_seq[k]), r - 1);
            end
            repeat (3) step();
         end
      end
   endtask

   task automatic test_reset();
      m_lfsr = 16'hACE1;
      rst = 1'b1;
      repeat (2) step();
      vecs++;
      if (o_led !== 4'b0000 || o_score !== 2'd0 || o_busy !== 1'b0 ||
          o_win !== 1'b0 || o_lose !== 1'b0) begin
         errs++;
         $display("FAIL reset_outputs: led=%b score=%0d busy=%b win=%b lose=%b, want all 0",
                  o_led, o_score, o_busy, o_win, o_lose);
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         btn = (k % 2 == 0) ? 4'b1111 : 4'b0000;
         step();
         vecs++;
         if (o_led !== 4'b0000 || o_score !== 2'd0 || o_busy !== 1'b0 ||
             o_win !== 1'b0 || o_lose !== 1'b0) begin
            errs++;
            $display("FAIL idle_quiet cyc %0d: led=%b score=%0d busy=%b win=%b lose=%b, want all 0",
                     k, o_led, o_score, o_busy, o_win, o_lose);
         end
      end
      btn = 4'b0000;
      step();
   endtask

   task automatic test_first_playback();
      do_start();
      c0 = m_seq[0];
      play(1, 1'b0);
   endtask

   task automatic test_full_win();
      for (int r = 1; r <= GL; r++) begin
         press_seq(r);
         vecs++;
         if (o_score !== SW'(r)) begin
            errs++;
            $display("FAIL round_score r%0d: score=%0d, want %0d", r, o_score, r);
         end
         if (r < GL) begin
            m_append();
            play(r + 1, 1'b0);
         end else begin
            vecs++;
            if (o_win !== 1'b1 || o_led !== 4'b1111 || o_busy !== 1'b0 || o_lose !== 1'b0) begin
               errs++;
               $display("FAIL win_state: win=%b led=%b busy=%b lose=%b, want 1 1111 0 0",
                        o_win, o_led, o_busy, o_lose);
            end
            repeat (3) step();
            vecs++;
            if (o_win !== 1'b1 || o_score !== 2'd3 || o_led !== 4'b1111) begin
               errs++;
               $display("FAIL win_hold: win=%b score=%0d led=%b, want 1 3 1111",
                        o_win, o_score, o_led);
            end
         end
      end
   endtask

   task automatic test_wrong_press();
      do_start();
      play(1, 1'b0);
      btn = oh((m_seq[0] + 1) % 4);
      step();
      btn = 4'b0000;
      vecs++;
      if (o_lose !== 1'b1 || o_score !== 2'd0 || o_led !== 4'b0000 ||
          o_busy !== 1'b0 || o_win !== 1'b0) begin
         errs++;
         $display("FAIL wrong_channel: lose=%b score=%0d led=%b busy=%b win=%b, want 1 0 0000 0 0",
                  o_lose, o_score, o_led, o_busy, o_win);
      end
      repeat (2) step();
      do_start();
      play(1, 1'b0);
      btn = 4'b0011;
      step();
      btn = 4'b0000;
      vecs++;
      if (o_lose !== 1'b1 || o_busy !== 1'b0 || o_led !== 4'b0000) begin
         errs++;
         $display("FAIL double_press: lose=%b busy=%b led=%b, want 1 0 0000",
                  o_lose, o_busy, o_led);
      end
      repeat (2) step();
   endtask

   task automatic test_timeout();
      do_start();
      play(1, 1'b0);
      press_seq(1);
      m_append();
      play(2, 1'b0);
      for (int k = 1; k < TO; k++) begin
         step();
         vecs++;
         if (o_lose !== 1'b0 || o_busy !== 1'b1) begin
            errs++;
            $display("FAIL timeout_early cyc %0d: lose=%b busy=%b, want 0 1", k, o_lose, o_busy);
         end
      end
      step();
      vecs++;
      if (o_lose !== 1'b1 || o_score !== 2'd1 || o_busy !== 1'b0 || o_led !== 4'b0000) begin
         errs++;
         $display("FAIL timeout_lose: lose=%b score=%0d busy=%b led=%b, want 1 1 0 0000",
                  o_lose, o_score, o_busy, o_led);
      end
      repeat (2) step();
      do_start();
      play(1, 1'b0);
      press_seq(1);
      m_append();
      play(2, 1'b0);
      repeat (TO - 1) step();
      btn = oh(m_seq[0]);
      step();
      btn = 4'b0000;
      vecs++;
      if (o_lose !== 1'b0 || o_busy !== 1'b1 || o_led !== oh(m_seq[0])) begin
         errs++;
         $display("FAIL press_at_limit: lose=%b busy=%b led=%b, want 0 1 %b",
                  o_lose, o_busy, o_led, oh(m_seq[0]));
      end
   endtask

   task automatic test_start_ignored_and_reset();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_lfsr = 16'hACE1;
      vecs++;
      if (o_led !== 4'b0000 || o_score !== 2'd0 || o_busy !== 1'b0 ||
          o_win !== 1'b0 || o_lose !== 1'b0) begin
         errs++;
         $display("FAIL mid_reset: led=%b score=%0d busy=%b win=%b lose=%b, want all 0",
                  o_led, o_score, o_busy, o_win, o_lose);
      end
      repeat (2) step();
      do_start();
      vecs++;
      if (o_led !== oh(c0)) begin
         errs++;
         $display("FAIL replay_seed: led=%b, want %b", o_led, oh(c0));
      end
      play(1, 1'b1);
      btn = oh(c0);
      step();
      btn = 4'b0000;
      vecs++;
      if (o_score !== 2'd1 || o_busy !== 1'b1 || o_led !== oh(c0) || o_lose !== 1'b0) begin
         errs++;
         $display("FAIL after_ignored_start: score=%0d busy=%b led=%b lose=%b, want 1 1 %b 0",
                  o_score, o_busy, o_led, o_lose, oh(c0));
      end
   endtask

   initial begin
      test_reset();
      test_first_playback();
      test_full_win();
      test_wrong_press();
      test_timeout();
      test_start_ignored_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
